// File: rtl/iq_word_decimator_if.sv
// Bundles the decimator's control, packed input word and decimated outputs
// into one interface.
//   master : drives word_in/word_valid/start/abort/record_len/dec_shift,
//            observes data_out_i/data_out_q/data_valid/busy/done
//   slave  : the decimator side (inverse directions)
interface iq_word_decimator_if #(
  parameter int unsigned SAMPLE_W = 16
);
  logic [8*SAMPLE_W-1:0] word_in;
  logic                  word_valid;
  logic                  start;
  logic                  abort;
  logic [31:0]           record_len;
  logic [3:0]            dec_shift;
  logic [SAMPLE_W-1:0]   data_out_i;
  logic [SAMPLE_W-1:0]   data_out_q;
  logic                  data_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output word_in, word_valid, start, abort, record_len, dec_shift,
    input  data_out_i, data_out_q, data_valid, busy, done
  );

  modport slave (
    input  word_in, word_valid, start, abort, record_len, dec_shift,
    output data_out_i, data_out_q, data_valid, busy, done
  );
endinterface

// File: rtl/iq_word_decimator.sv
// Averages the four signed I and four signed Q lanes of each packed word, then
// block-averages 2^dec_shift words into one decimated I/Q sample. Emits
// record_len samples per armed record, then pulses done.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave modport of iq_word_decimator_if
//              (word_in {i0..i3,q0..q3}, word_valid, start, abort, record_len,
//               dec_shift in; data_out_i/q, data_valid, busy, done out)
module iq_word_decimator #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEC_MAX  = 8,
  parameter int unsigned ACC_W    = 26
) (
  input  logic               clk,
  input  logic               rst,
  iq_word_decimator_if.slave bus
);
  localparam int unsigned SUM_W = SAMPLE_W + 2;
  localparam int unsigned SH_W  = 4;
  localparam int unsigned CNT_W = DEC_MAX;
  localparam int unsigned LEN_W = 32;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, ocnt_q;
  logic [SH_W-1:0]           shift_q, shift_clamp;
  logic [CNT_W-1:0]          wcnt_q, wcnt_last;
  logic [CNT_W:0]            blk_len;
  logic [SH_W:0]             sh_amt;
  logic signed [ACC_W-1:0]   acc_i_q, acc_q_q, base_i, base_q, tot_i, tot_q;
  logic signed [SUM_W-1:0]   si_q, sq_q, lane_i_sum, lane_q_sum;
  logic                      sv_q;
  logic                      block_end, last_out;
  logic                      data_valid_d, done_d, busy_d;
  logic [SAMPLE_W-1:0]       out_i_q, out_q_q;
  logic                      data_valid_q, done_q, busy_q;

  // Lane sums of the incoming word, sign-extended to SUM_W
  always_comb begin
    lane_i_sum = '0;
    lane_q_sum = '0;
    for (int n = 0; n < 4; n++) begin
      lane_i_sum = lane_i_sum + SUM_W'($signed(bus.word_in[(7-n)*SAMPLE_W +: SAMPLE_W]));
      lane_q_sum = lane_q_sum + SUM_W'($signed(bus.word_in[(3-n)*SAMPLE_W +: SAMPLE_W]));
    end
  end

  // Block bookkeeping and running totals for the stage-2 word
  always_comb begin
    shift_clamp = (bus.dec_shift > SH_W'(DEC_MAX)) ? SH_W'(DEC_MAX) : bus.dec_shift;
    blk_len     = (CNT_W+1)'(1) << shift_q;
    wcnt_last   = CNT_W'(blk_len - (CNT_W+1)'(1));
    sh_amt      = (SH_W+1)'(shift_q) + (SH_W+1)'(2);
    base_i      = (wcnt_q == '0) ? '0 : acc_i_q;
    base_q      = (wcnt_q == '0) ? '0 : acc_q_q;
    tot_i       = base_i + ACC_W'(si_q);
    tot_q       = base_q + ACC_W'(sq_q);
    block_end   = (state_q == RUN) && sv_q && (wcnt_q == wcnt_last);
    last_out    = block_end && ((ocnt_q + LEN_W'(1)) == len_q);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; abort takes priority over the final output
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && (bus.record_len != '0)) state_d = RUN;
      RUN:     if (bus.abort || last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    data_valid_d = 1'b0;
    done_d       = 1'b0;
    busy_d       = (state_d == RUN);
    case (state_q)
      IDLE: done_d = bus.start && (bus.record_len == '0);
      RUN: begin
        data_valid_d = block_end && !bus.abort;
        done_d       = last_out && !bus.abort;
      end
      default: ;
    endcase
  end

  // Stage-1 lane sums, stage-2 accumulation and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      ocnt_q       <= '0;
      shift_q      <= '0;
      wcnt_q       <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      si_q         <= '0;
      sq_q         <= '0;
      sv_q         <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      data_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= data_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      sv_q         <= (state_q == RUN) && bus.word_valid;
      if ((state_q == RUN) && bus.word_valid) begin
        si_q <= lane_i_sum;
        sq_q <= lane_q_sum;
      end
      if ((state_q == IDLE) && (state_d == RUN)) begin
        len_q   <= bus.record_len;
        shift_q <= shift_clamp;
        wcnt_q  <= '0;
        ocnt_q  <= '0;
      end else if ((state_q == RUN) && sv_q && !bus.abort) begin
        if (wcnt_q == wcnt_last) begin
          // Dividing by 4*2^shift with an arithmetic shift gives the floored mean
          out_i_q <= SAMPLE_W'(tot_i >>> sh_amt);
          out_q_q <= SAMPLE_W'(tot_q >>> sh_amt);
          wcnt_q  <= '0;
          ocnt_q  <= ocnt_q + LEN_W'(1);
        end else begin
          acc_i_q <= tot_i;
          acc_q_q <= tot_q;
          wcnt_q  <= wcnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.data_out_i = out_i_q;
  assign bus.data_out_q = out_q_q;
  assign bus.data_valid = data_valid_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_iq_word_decimator.sv
// Bench for iq_word_decimator: a record-level reference model predicts every
// output each cycle; directed records pin the model with literal values.
module tb_iq_word_decimator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  iq_word_decimator_if bus ();
  iq_word_decimator dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ---------------- reference model (record level) ----------------
  bit          m_active = 1'b0;
  int unsigned m_len = 0, m_nout = 0;
  int          m_shift = 0;
  int          m_blk_i[$], m_blk_q[$];
  bit          p_valid = 1'b0;
  int          p_i = 0, p_q = 0;
  bit          exp_valid = 1'b0, exp_done = 1'b0, exp_busy = 1'b0;
  int          exp_i = 0, exp_q = 0;

  function automatic int floor_mean(input int total, input int n);
    int r;
    r = total / n;
    if ((total % n) != 0 && total < 0) r = r - 1;
    return r;
  endfunction

  always @(posedge clk) begin
    bit acc_now;
    int wi, wq, si, sq;
    logic [127:0] w;
    cyc++;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    w  = bus.word_in;
    wi = 0;
    wq = 0;
    for (int n = 0; n < 4; n++) begin
      wi += int'($signed(w[(7-n)*16 +: 16]));
      wq += int'($signed(w[(3-n)*16 +: 16]));
    end
    acc_now = m_active && bus.word_valid;
    if (rst) begin
      m_active = 1'b0;
      m_blk_i.delete();
      m_blk_q.delete();
      exp_i   = 0;
      exp_q   = 0;
      acc_now = 1'b0;
    end else if (!m_active) begin
      if (bus.start) begin
        if (bus.record_len == 0) exp_done = 1'b1;
        else begin
          m_active = 1'b1;
          m_len    = bus.record_len;
          m_shift  = (bus.dec_shift > 8) ? 8 : int'(bus.dec_shift);
          m_nout   = 0;
          m_blk_i.delete();
          m_blk_q.delete();
        end
      end
    end else if (bus.abort) begin
      m_active = 1'b0;
    end else if (p_valid) begin
      m_blk_i.push_back(p_i);
      m_blk_q.push_back(p_q);
      if (m_blk_i.size() == (1 << m_shift)) begin
        si = 0;
        sq = 0;
        foreach (m_blk_i[k]) begin
          si += m_blk_i[k];
          sq += m_blk_q[k];
        end
        exp_i     = floor_mean(si, 4 << m_shift);
        exp_q     = floor_mean(sq, 4 << m_shift);
        exp_valid = 1'b1;
        m_nout++;
        m_blk_i.delete();
        m_blk_q.delete();
        if (m_nout == m_len) begin
          exp_done = 1'b1;
          m_active = 1'b0;
        end
      end
    end
    p_valid  = acc_now;
    p_i      = wi;
    p_q      = wq;
    exp_busy = m_active;
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  int s_i[$], s_q[$], s_cyc[$], d_cyc[$];

  always @(posedge clk) begin
    #2;
    check("data_valid", int'(bus.data_valid), int'(exp_valid));
    check("done", int'(bus.done), int'(exp_done));
    check("busy", int'(bus.busy), int'(exp_busy));
    check("data_out_i", int'($signed(bus.data_out_i)), exp_i);
    check("data_out_q", int'($signed(bus.data_out_q)), exp_q);
    if (bus.data_valid) begin
      s_i.push_back(int'($signed(bus.data_out_i)));
      s_q.push_back(int'($signed(bus.data_out_q)));
      s_cyc.push_back(cyc);
    end
    if (bus.done) d_cyc.push_back(cyc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_word(input int i0, i1, i2, i3, q0, q1, q2, q3);
    bus.word_in = {16'(i0), 16'(i1), 16'(i2), 16'(i3), 16'(q0), 16'(q1), 16'(q2), 16'(q3)};
  endtask

  task automatic start_rec(input int unsigned len, input int unsigned sh);
    bus.start      = 1'b1;
    bus.record_len = len;
    bus.dec_shift  = 4'(sh);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.word_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_logs();
    s_i.delete();
    s_q.delete();
    s_cyc.delete();
    d_cyc.delete();
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_i0"}, int'(bus.data_out_i), 0);
    check({name, "_q0"}, int'(bus.data_out_q), 0);
    check({name, "_dv0"}, int'(bus.data_valid), 0);
    check({name, "_busy0"}, int'(bus.busy), 0);
    check({name, "_done0"}, int'(bus.done), 0);
  endtask

  int w_first, w4, w8, w_last;

  initial begin
    bus.word_in    = '0;
    bus.word_valid = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.record_len = '0;
    bus.dec_shift  = '0;
    #1 rst = 1'b1;
    tick();
    tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // 1: constant lanes, shift 0, len 3
    clear_logs();
    start_rec(3, 0);
    set_word(1000, 1000, 1000, 1000, -1000, -1000, -1000, -1000);
    bus.word_valid = 1'b1;
    w_first = cyc + 1;
    repeat (3) tick();
    idle(4);
    check("t1_count", s_i.size(), 3);
    if (s_i.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("t1_i", s_i[k], 1000);
        check("t1_q", s_q[k], -1000);
      end
      check("t1_latency", s_cyc[0] - w_first, 1);
      check("t1_done_count", d_cyc.size(), 1);
      if (d_cyc.size() == 1) check("t1_done_cycle", d_cyc[0], s_cyc[2]);
    end

    // 2: floor of fractional means
    clear_logs();
    start_rec(1, 0);
    set_word(3, 0, 0, 0, -3, 0, 0, 0);
    bus.word_valid = 1'b1;
    tick();
    idle(4);
    check("t2_count", s_i.size(), 1);
    if (s_i.size() == 1) begin
      check("t2_i", s_i[0], 0);
      check("t2_q", s_q[0], -1);
    end

    // 3: shift 2, ramp of lane sums 4..32
    clear_logs();
    start_rec(2, 2);
    w4 = 0;
    w8 = 0;
    for (int k = 1; k <= 8; k++) begin
      set_word(k, k, k, k, 0, 0, 0, 0);
      bus.word_valid = 1'b1;
      if (k == 4) w4 = cyc + 1;
      if (k == 8) w8 = cyc + 1;
      tick();
    end
    idle(4);
    check("t3_count", s_i.size(), 2);
    if (s_i.size() == 2) begin
      check("t3_i0", s_i[0], 2);
      check("t3_i1", s_i[1], 6);
      check("t3_q0", s_q[0], 0);
      check("t3_cyc0", s_cyc[0], w4 + 1);
      check("t3_cyc1", s_cyc[1], w8 + 1);
    end

    // 4: gaps in word_valid hold the partial sum
    clear_logs();
    start_rec(1, 1);
    set_word(10, 10, 10, 10, -7, -7, -7, -7);
    bus.word_valid = 1'b1;
    tick();
    set_word(999, 999, 999, 999, 999, 999, 999, 999);
    idle(2);
    set_word(20, 20, 20, 20, 5, 5, 5, 5);
    bus.word_valid = 1'b1;
    w_last = cyc + 1;
    tick();
    idle(4);
    check("t4_count", s_i.size(), 1);
    if (s_i.size() == 1) begin
      check("t4_i", s_i[0], 15);
      check("t4_q", s_q[0], -1);
      check("t4_cyc", s_cyc[0], w_last + 1);
    end

    // 5a: abort mid-block, then a clean record
    clear_logs();
    start_rec(2, 3);
    set_word(500, 500, 500, 500, 500, 500, 500, 500);
    bus.word_valid = 1'b1;
    repeat (5) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t5_busy_after_abort", int'(bus.busy), 0);
    idle(3);
    check("t5_abort_strobes", s_i.size(), 0);
    check("t5_abort_done", d_cyc.size(), 0);
    start_rec(1, 0);
    set_word(100, 100, 100, 100, -50, -50, -50, -50);
    bus.word_valid = 1'b1;
    tick();
    idle(4);
    check("t5_clean_count", s_i.size(), 1);
    if (s_i.size() == 1) begin
      check("t5_clean_i", s_i[0], 100);
      check("t5_clean_q", s_q[0], -50);
    end

    // 5b: reset mid-record clears outputs at once
    clear_logs();
    start_rec(5, 2);
    set_word(300, 300, 300, 300, 300, 300, 300, 300);
    bus.word_valid = 1'b1;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check_zero_outputs("t5_rst");
    tick();
    rst = 1'b0;
    idle(3);
    check("t5_rst_done", d_cyc.size(), 0);

    // 6a: zero-length record
    clear_logs();
    start_rec(0, 0);
    idle(3);
    check("t6_len0_done", d_cyc.size(), 1);
    check("t6_len0_strobes", s_i.size(), 0);

    // 6b: clamped shift and full-scale lanes
    clear_logs();
    start_rec(1, 15);
    set_word(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767);
    bus.word_valid = 1'b1;
    w_last = 0;
    for (int k = 1; k <= 256; k++) begin
      if (k == 256) w_last = cyc + 1;
      tick();
    end
    idle(4);
    check("t6_fs_count", s_i.size(), 1);
    if (s_i.size() == 1) begin
      check("t6_fs_i", s_i[0], -32768);
      check("t6_fs_q", s_q[0], 32767);
      check("t6_fs_cyc", s_cyc[0], w_last + 1);
    end

    // Randomized records against the model
    for (int r = 0; r < 40; r++) begin
      int budget;
      bus.abort = ($urandom_range(0, 7) == 0);
      start_rec($urandom_range(1, 4), ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15)
                                                                 : $urandom_range(0, 3));
      bus.abort = 1'b0;
      budget = 0;
      while (m_active && budget < 3000) begin
        set_word($urandom_range(0, 65535), $urandom_range(0, 65535),
                 $urandom_range(0, 65535), $urandom_range(0, 65535),
                 $urandom_range(0, 65535), $urandom_range(0, 65535),
                 $urandom_range(0, 65535), $urandom_range(0, 65535));
        bus.word_valid = ($urandom_range(0, 9) < 7);
        bus.start      = ($urandom_range(0, 15) == 0);
        bus.record_len = $urandom_range(0, 3);
        bus.abort      = ($urandom_range(0, 99) == 0);
        tick();
        budget++;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("rand_record_timeout", int'(m_active), 0);
      idle($urandom_range(1, 3));
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
